psum_accum: RTL
===============

# psum_accum

Multi-pass partial-sum accumulator sitting directly upstream of the INT32→INT8 quantization stage. Receives AXI-width beats of INT32 partial sums from the compute array, one pass per K-tile. It accumulates them per lane with saturation in an on-chip tile buffer. On the final pass it streams the completed INT32 accumulators downstream with valid/ready and `out_last`.

## Interface
- `ACC_WIDTH`, 32, accumulator lane width (signed)
- `AXI_WIDTH`, 128, beat width; `LANES = AXI_WIDTH/ACC_WIDTH`
- `DEPTH`, 64, tile buffer depth in beats (power of two)

- `clk`  in  1  clock
- `rst_b`  in  1  reset, asynchronous, active-low
- `cfg_wr_en`  in  1  config write strobe
- `cfg_addr`  in  6  config address; this block decodes `cfg_addr[5:4]==2'b00` only
- `cfg_wdata`  in  64  config data
- `in_valid` / `in_ready`  in/out  1  partial-sum beat handshake
- `in_data`  in  AXI_WIDTH  LANES signed partial sums, lane i at `[i*ACC_WIDTH +: ACC_WIDTH]`
- `in_last`  in  1  last beat of a pass
- `out_valid` / `out_ready`  out/in  1  accumulator beat handshake
- `out_data`  out  AXI_WIDTH  accumulated INT32 lanes
- `out_last`  out  1  last beat of tile
- `busy`  out  1  state != IDLE
- `err_sat`  out  1  sticky: any lane saturated
- `err_len`  out  1  sticky: `in_last` misaligned with `tile_beats`

## Operation
- Config addr 0x00: `tile_beats = wdata[6:0]`, clamped to 1..DEPTH; `num_passes = wdata[31:16]`, 0 treated as 1. Reset values: DEPTH and 1.
- Config addr 0x01: `wdata[0]` clears `err_sat`; `wdata[1]` clears `err_len`. Honoured in any state.
- Addr 0x00 writes apply only in IDLE, and only in a cycle with no accepted beat. Otherwise they are dropped.
- Counters:
  - `beat_cnt`: 0..tile_beats-1.
  - `pass_cnt`: 0..num_passes-1.
- Buffer: DEPTH × AXI_WIDTH register array with combinational read at `beat_cnt`.
- FSM:
  - **IDLE**: the first accepted beat is pass 0, beat 0. Next state is ACCUM if `num_passes>1`, else FINAL (that beat is already processed as FINAL).
  - **ACCUM** (passes 0..num_passes-2):
    - Pass 0 writes `in_data` into the buffer.
    - Later passes write `sat_add(buf, in_data)`.
    - `in_ready=1`.
  - **FINAL** (last pass):
    - Computes `sat_add(buf, in_data)`, or `in_data` when `num_passes==1`, into `out_data`.
    - No buffer write.
    - `in_ready = out_ready || !out_valid`.
    - After the end-of-pass beat is accepted, go to IDLE.
- End of pass: an accepted beat with `in_last`, or with `beat_cnt==tile_beats-1`, whichever comes first.
  - Clear `beat_cnt`.
  - Increment `pass_cnt`; on the FINAL transition, clear it.
  - If `in_last` and `beat_cnt==tile_beats-1` disagree, set `err_len`. The pass is still terminated.
- `sat_add`: per-lane signed 32+32. On overflow, clamp to 0x7FFFFFFF / 0x80000000 and set `err_sat`.
- `out_last` = end-of-pass beat in FINAL.
- In IDLE, `in_ready = 1` if `num_passes>1`, else the FINAL rule.

## Timing
- Reset values:
  - Outputs: `out_valid`, `out_last`, `busy`, `err_sat`, `err_len` = 0; `out_data` = 0.
  - Internal: state IDLE, counters 0.
  - Buffer contents are not reset.
- Latency: FINAL beat accepted at edge N → `out_valid=1` with data after edge N.
- Throughput: 1 beat/cycle in all states with no bubbles, including pass boundaries and back-to-back tiles (IDLE re-entry accepts a beat the same cycle).
- `out_valid` holds, with data stable, until `out_ready`. It drops the cycle after handshake unless a new beat is accepted in the same cycle (refill).
- Asserting `rst_b` mid-tile discards all progress; the bench restarts from pass 0.
- A clear write (0x01) in the same cycle as a new error event: the error wins and stays set.

## Structure
- Package `psum_pkg` holds:
  - `LANES`
  - cfg address constants `CFG_TILE=6'h00` and `CFG_CLR=6'h01`
  - state enum `{IDLE, ACCUM, FINAL}`
- Sub-module `psum_sat_add` (one lane: sum plus overflow flag), instantiated LANES times.

## Test plan
- **Single pass**: `tile_beats=4`, `num_passes=1`, lanes {1,2,3,4} on each beat, `out_ready=1`. Expect 4 outputs equal to the inputs, `out_last` on the 4th, 1-cycle latency, `err_*=0`.
- **Three passes**: `tile_beats=2`, lane value k on pass k (k=1..3). Expect outputs with all lanes = 6, `out_last` on beat 2, `busy` falling after.
- **Saturation**: 2 passes of 0x7FFFFFF0 and 0x20 on lane 0, -0x80000000 and -1 on lane 1. Expect 0x7FFFFFFF and 0x80000000, `err_sat=1`. A write to 0x01 with `wdata=1` clears it.
- **Backpressure**: random `out_ready` at 30% during FINAL. Expect no lost or duplicated beats, `out_data` stable while stalled, and ACCUM passes never stall.
- **Length error**: `tile_beats=4`, `in_last` on beat 3. Expect `err_len=1` and the pass terminated at 3 beats. Also send 4 beats without `in_last`: expect `err_len=1` and the next beat treated as beat 0.
- **Reset mid-tile, then config**: assert reset during pass 2 of 3. Expect outputs zero and `busy=0`. A config write in IDLE then takes effect; a config write while `busy=1` is ignored.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared constants and types for the multi-pass partial-sum accumulator.
package psum_pkg;

    localparam int ACC_W_DEF = 32;
    localparam int AXI_W_DEF = 128;
    localparam int LANES     = AXI_W_DEF / ACC_W_DEF;

    localparam logic [5:0] CFG_TILE = 6'h00;
    localparam logic [5:0] CFG_CLR  = 6'h01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2
    } state_t;

endpackage

// File: rtl/psum_sat_add.sv
// One accumulator lane: signed add that clamps to the representable range and flags overflow.
module psum_sat_add #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    function automatic logic signed [W-1:0] sat_clamp(input logic neg);
        sat_clamp = neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    endfunction

    logic signed [W-1:0] raw;

    always_comb begin
        raw = a + b;
        ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
        sum = ovf ? sat_clamp(a[W-1]) : raw;
    end

endmodule

// File: rtl/psum_accum.sv
// Multi-pass INT32 partial-sum accumulator: sums K-tile passes per lane in a tile buffer
// and streams the finished accumulators on the last pass.
module psum_accum
    import psum_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int AXI_WIDTH = 128,
    parameter int DEPTH     = 64
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 cfg_wr_en,
    input  logic [5:0]           cfg_addr,
    input  logic [63:0]          cfg_wdata,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AXI_WIDTH-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AXI_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err_sat,
    output logic                 err_len
);

    localparam int BW = $clog2(DEPTH);
    localparam int TW = BW + 1;

    state_t               state, state_nxt;
    logic [BW-1:0]        beat_cnt;
    logic [TW-1:0]        tile_beats, tile_new;
    logic [15:0]          num_passes, passes_new, pass_cnt;
    logic [AXI_WIDTH-1:0] buf_mem [DEPTH];
    logic [AXI_WIDTH-1:0] buf_rd, sum_data, acc_data;
    logic [LANES-1:0]     lane_ovf;
    logic fire, eop, at_end, is_final, first_pass, len_bad, sat_hit, buf_we;
    logic cfg_tile_we, cfg_clr_we;
    logic unused_cfg_bits;

    assign unused_cfg_bits = ^{cfg_wdata[63:32], cfg_wdata[15:7]};
    assign buf_rd = buf_mem[beat_cnt];
    assign busy   = (state != IDLE);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        psum_sat_add #(.W(ACC_WIDTH)) u_sat (
            .a   (buf_rd[g*ACC_WIDTH +: ACC_WIDTH]),
            .b   (in_data[g*ACC_WIDTH +: ACC_WIDTH]),
            .sum (sum_data[g*ACC_WIDTH +: ACC_WIDTH]),
            .ovf (lane_ovf[g])
        );
    end

    // Pass position is tracked by pass_cnt, so IDLE behaves as pass 0 beat 0.
    always_comb begin
        is_final   = (pass_cnt == num_passes - 16'd1);
        first_pass = (pass_cnt == 16'd0);
        in_ready   = is_final ? (out_ready || !out_valid) : 1'b1;
        fire       = in_valid && in_ready;
        at_end     = ({1'b0, beat_cnt} == tile_beats - TW'(1));
        eop        = fire && (in_last || at_end);
        len_bad    = fire && (in_last != at_end);
        acc_data   = first_pass ? in_data : sum_data;
        sat_hit    = fire && !first_pass && (|lane_ovf);
        buf_we     = fire && !is_final;
        state_nxt  = state;
        if (eop) begin
            if (is_final)
                state_nxt = IDLE;
            else if (pass_cnt + 16'd1 == num_passes - 16'd1)
                state_nxt = FINAL;
            else
                state_nxt = ACCUM;
        end else if (fire) begin
            state_nxt = is_final ? FINAL : ACCUM;
        end
    end

    always_comb begin
        cfg_tile_we = cfg_wr_en && (cfg_addr == CFG_TILE) && (state == IDLE) && !fire;
        cfg_clr_we  = cfg_wr_en && (cfg_addr == CFG_CLR);
        if (cfg_wdata[6:0] == 7'd0)
            tile_new = TW'(1);
        else if ({25'd0, cfg_wdata[6:0]} > DEPTH)
            tile_new = TW'(DEPTH);
        else
            tile_new = TW'(cfg_wdata[6:0]);
        passes_new = (cfg_wdata[31:16] == 16'd0) ? 16'd1 : cfg_wdata[31:16];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            beat_cnt   <= '0;
            pass_cnt   <= '0;
            tile_beats <= TW'(DEPTH);
            num_passes <= 16'd1;
        end else begin
            if (eop) begin
                beat_cnt <= '0;
                pass_cnt <= is_final ? 16'd0 : pass_cnt + 16'd1;
            end else if (fire) begin
                beat_cnt <= beat_cnt + BW'(1);
            end
            if (cfg_tile_we) begin
                tile_beats <= tile_new;
                num_passes <= passes_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we)
            buf_mem[beat_cnt] <= acc_data;
    end

    // Output stage: one register slice, refilled in the same cycle it drains.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (fire && is_final) begin
            out_valid <= 1'b1;
            out_last  <= eop;
            out_data  <= acc_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err_sat <= 1'b0;
            err_len <= 1'b0;
        end else begin
            err_sat <= sat_hit | (err_sat & ~(cfg_clr_we & cfg_wdata[0]));
            err_len <= len_bad | (err_len & ~(cfg_clr_we & cfg_wdata[1]));
        end
    end

endmodule
